// File: rtl/veda_fetch.sv
// VEDA instruction fetch stage: holds the PC, reads instruction memory combinationally and
// registers the fetched word for decode. Stops on the halt opcode or an out-of-range PC until redirected.
module veda_fetch #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 32,
    parameter int                IMEM_DEPTH = 200,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [5:0]        HALT_OP    = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_mode,
    output logic              imem_w_en,
    output logic [DATA_W-1:0] imem_datain,
    input  logic [DATA_W-1:0] imem_dataout,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    // One extra bit so the depth limit still compares correctly when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(IMEM_DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              w_pc_oob;
    logic              w_is_halt;
    logic              w_advance;

    // The fault test never looks at memory content, so it takes precedence over the halt test.
    assign w_pc_oob  = {1'b0, r_pc} >= DEPTH_LIMIT;
    assign w_is_halt = imem_dataout[DATA_W-1 -: 6] == HALT_OP;
    assign w_advance = (r_state == S_RUN) && !branch_taken && !stall;

    // NOTE: state lives in always_ff with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_state_next = r_state;
        if (branch_taken) begin
            w_state_next = S_RUN;
        end else if (w_advance) begin
            if (w_pc_oob) begin
                w_state_next = S_FAULT;
            end else if (w_is_halt) begin
                w_state_next = S_HALT;
            end
        end
    end

    always_comb begin
        halted = 1'b0;
        fault  = 1'b0;
        case (r_state)
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    // A redirect drops the in-flight word, leaving exactly one bubble before the target arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (branch_taken) begin
            r_pc          <= branch_target;
            r_instr_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_pc_oob || w_is_halt) begin
                r_instr_valid <= 1'b0;
            end else begin
                r_instr       <= imem_dataout;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 1'b1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign imem_mode   = 1'b1;
    assign imem_w_en   = 1'b0;
    assign imem_datain = '0;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule
